// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates one single-port, variable-latency memory between an instruction
// fetch requester (IF) and a data-stage requester (DM).
//
// Ports:
//   clk, rst                 clock (rising edge) and synchronous active-low reset
//   ifReq, ifAddr, ifFlush   fetch request, fetch address, discard of fetch result
//   dmRead, dmWrite          data-stage read / write request (write wins if both)
//   dmAddr, dmWdata          data-stage address and write data
//   ifRdata, ifReady         fetch read data and its one-cycle completion pulse
//   dmRdata, dmReady         data read data and its one-cycle completion pulse
//   memEn, memWe             memory access active / access is a write
//   memAddr, memWdata        address and write data held for the whole access
//   memRdata, memAck         memory read data and completion strobe
//   stall                    combinational pipeline stall
//   errTimeout               sticky flag: an access was abandoned by the watchdog
//   ifGrants, dmGrants       saturating grant counters

module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    input  logic        ifFlush,
    input  logic        dmRead,
    input  logic        dmWrite,
    input  logic [31:0] dmAddr,
    input  logic [31:0] dmWdata,
    output logic [31:0] ifRdata,
    output logic        ifReady,
    output logic [31:0] dmRdata,
    output logic        dmReady,
    output logic        memEn,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        stall,
    output logic        errTimeout,
    output logic [15:0] ifGrants,
    output logic [15:0] dmGrants
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        if_pending;
    logic        dm_req;
    logic        grant_if;
    logic        grant_dm;
    logic        done;
    logic        timeout;
    logic        if_drop;
    logic [3:0]  watchdog;
    logic [1:0]  fair_cnt;
    logic        flush_seen;

    // A fetch only competes for the memory while it is not being flushed.
    assign if_pending = ifReq & ~ifFlush;
    assign dm_req     = dmRead | dmWrite;
    assign memEn      = (state != IDLE);
    assign stall      = (if_pending & ~ifReady) | (dm_req & ~dmReady);

    // The fetch result is discarded if a flush was seen in any busy cycle,
    // including the cycle in which the memory completes.
    assign if_drop    = flush_seen | ifFlush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DM normally has priority; once DM has won three times in a row while a
    // fetch was waiting, the fetch gets the next grant. In a busy state the
    // access ends on memAck or when the watchdog is about to reach 15, which
    // happens on the 15th busy cycle without an acknowledge.
    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (if_pending && fair_cnt == 2'd3) begin
                    grant_if = 1'b1;
                end else if (dm_req) begin
                    grant_dm = 1'b1;
                end else if (if_pending) begin
                    grant_if = 1'b1;
                end
                if (grant_dm) begin
                    next_state = DM_BUSY;
                end else if (grant_if) begin
                    next_state = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (memAck) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (watchdog == 4'd14) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Access registers, returned data, ready pulses, watchdog, fairness and
    // grant counters. The memory-side registers only change on a grant, so
    // they hold steady for the whole access. IF grants carry no write data,
    // so memWdata is cleared for them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            memAddr    <= 32'h0;
            memWdata   <= 32'h0;
            memWe      <= 1'b0;
            ifRdata    <= 32'h0;
            dmRdata    <= 32'h0;
            ifReady    <= 1'b0;
            dmReady    <= 1'b0;
            errTimeout <= 1'b0;
            ifGrants   <= 16'h0;
            dmGrants   <= 16'h0;
            watchdog   <= 4'd0;
            fair_cnt   <= 2'd0;
            flush_seen <= 1'b0;
        end else begin
            ifReady <= 1'b0;
            dmReady <= 1'b0;

            if (grant_if || grant_dm) begin
                memAddr    <= grant_dm ? dmAddr : ifAddr;
                memWdata   <= grant_dm ? dmWdata : 32'h0;
                memWe      <= grant_dm & dmWrite;
                watchdog   <= 4'd0;
                flush_seen <= 1'b0;
            end

            if (grant_if && ifGrants != 16'hFFFF) begin
                ifGrants <= ifGrants + 16'd1;
            end
            if (grant_dm && dmGrants != 16'hFFFF) begin
                dmGrants <= dmGrants + 16'd1;
            end

            if (!ifReq || grant_if) begin
                fair_cnt <= 2'd0;
            end else if (grant_dm && if_pending && fair_cnt != 2'd3) begin
                fair_cnt <= fair_cnt + 2'd1;
            end

            if (memEn) begin
                if (!memAck) begin
                    watchdog <= watchdog + 4'd1;
                end
                if (state == IF_BUSY && ifFlush) begin
                    flush_seen <= 1'b1;
                end
                if (timeout) begin
                    errTimeout <= 1'b1;
                end
                if ((done || timeout) && state == IF_BUSY && !if_drop) begin
                    ifReady <= 1'b1;
                    ifRdata <= done ? memRdata : 32'h0;
                end
                if ((done || timeout) && state == DM_BUSY) begin
                    dmReady <= 1'b1;
                    if (timeout) begin
                        dmRdata <= 32'h0;
                    end else if (!memWe) begin
                        dmRdata <= memRdata;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have the ports below; one clock; rst is synchronous and active-low. Listed as name, direction, width, meaning.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-low reset.
REQ-004 ifReq  in  1, ifAddr  in  32, ifFlush  in  1  fetch request, fetch address, fetch-result discard.
REQ-005 dmRead  in  1, dmWrite  in  1, dmAddr  in  32, dmWdata  in  32  data-stage access.
REQ-006 ifRdata  out  32, ifReady  out  1, dmRdata  out  32, dmReady  out  1  returned data and 1-cycle completion pulses.
REQ-007 memEn  out  1, memWe  out  1, memAddr  out  32, memWdata  out  32, memRdata  in  32, memAck  in  1  shared single-port memory, variable latency.
REQ-008 stall  out  1, errTimeout  out  1, ifGrants  out  16, dmGrants  out  16  pipeline stall, sticky timeout flag, grant counters.

Function
REQ-009 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY.
REQ-010 IDLE SHALL grant DM when dmRead|dmWrite, else IF when ifReq & ~ifFlush, else stay IDLE; fairness per REQ-013 overrides.
REQ-011 On grant SHALL latch address/data/write-enable into memAddr/memWdata/memWe registers; memWe=dmWrite for DM grants, 0 for IF grants; dmWrite wins if dmRead and dmWrite are both high.
REQ-012 memEn SHALL be 1 exactly while in IF_BUSY or DM_BUSY; memAddr/memWdata/memWe SHALL stay stable for the whole busy state.
REQ-013 Fairness: 2-bit counter of consecutive DM grants while ifReq & ~ifFlush was pending; when it reaches 3 and IF is still pending, next IDLE grant goes to IF; counter clears on any IF grant or when ifReq is low.
REQ-014 In busy state, memAck SHALL capture memRdata into ifRdata/dmRdata (reads only; dmRdata unchanged on write), pulse matching ready next cycle for one cycle, and return to IDLE.
REQ-015 Latency: request seen in IDLE cycle N -> memEn cycle N+1; memAck in cycle M>=N+1 -> ready and IDLE in cycle M+1; minimum 2 cycles request-to-ready; one IDLE turnaround cycle between transactions.
REQ-016 If ifFlush is high in any cycle of IF_BUSY, the transaction SHALL complete on memory but ifReady SHALL be suppressed and ifRdata left unchanged.
REQ-017 Dropping a request mid-transaction SHALL NOT abort it; ready still pulses.
REQ-018 4-bit watchdog SHALL clear on entry to a busy state and increment each busy cycle without memAck; at 15, SHALL return to IDLE, set errTimeout (sticky until reset), pulse the matching ready with rdata 32'h0.
REQ-019 ifGrants/dmGrants SHALL increment on each grant, saturating at 16'hFFFF.
REQ-020 stall SHALL equal (ifReq & ~ifFlush & ~ifReady) | ((dmRead|dmWrite) & ~dmReady), combinational.
REQ-021 memAck in IDLE SHALL be ignored.

Reset
REQ-022 rst low at a clock edge SHALL force IDLE, memEn=0, memWe=0, memAddr=0, memWdata=0, ifRdata=0, dmRdata=0, ifReady=0, dmReady=0, errTimeout=0, counters/watchdog/fairness=0, even mid-transaction; a late memAck after reset SHALL be ignored.

Verification
REQ-023 ifReq, ifAddr=0x40, memAck 1 cycle after memEn, memRdata=0x1234 -> memEn cycles N+1..N+2, ifReady at N+3, ifRdata=0x1234, ifGrants=1.
REQ-024 ifReq and dmWrite same cycle, dmAddr=0x80, dmWdata=0xAA -> DM first (memWe=1, memAddr=0x80), dmReady, one IDLE cycle, then IF grant; stall high until each ready.
REQ-025 ifReq held, dmRead re-asserted after every dmReady -> at most 3 consecutive DM grants before one IF grant.
REQ-026 memAck never asserted -> after 15 busy cycles ready pulses with rdata 0, errTimeout=1 and stays 1 until rst.
REQ-027 ifFlush pulsed during IF_BUSY -> no ifReady, ifRdata unchanged, next grant proceeds normally.
REQ-028 rst asserted in DM_BUSY, memAck on next cycle -> all outputs at reset values, no dmReady.
